// File: rtl/vertexinput_reg_ctrl.sv
// AXI-lite bridge to one-hot register slices; one transaction at a time, read/write round-robin.
// Write grant->bvalid 2 cycles, read grant->rvalid 3 cycles; responses hold until bready/rready.
module vertexinput_reg_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    output logic [1:0]                     s_bresp,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic [NUM_REGS-1:0]            mem_w_req,
    output logic [DATA_WIDTH-1:0]          mem_w_data,
    output logic [NUM_REGS-1:0]            mem_r_req,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] mem_r_data_local
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_EXEC = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_EXEC = 3'd3;
    localparam logic [2:0] RD_CAPT = 3'd4;
    localparam logic [2:0] RD_RESP = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]            state_q, state_d;
    logic                  prio_wr_q, prio_wr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  wr_elig, rd_elig, grant_wr, grant_rd;
    logic                  idx_in_range, wr_ok;
    logic [NUM_REGS-1:0]   idx_onehot;
    logic [DATA_WIDTH-1:0] slice_sel;
    logic [1:0]            unused_addr_lsbs;

    // Byte offset within a register carries no meaning for these slices.
    assign unused_addr_lsbs = s_awaddr[1:0] ^ s_araddr[1:0];

    assign wr_elig  = s_awvalid & s_wvalid;
    assign rd_elig  = s_arvalid;
    assign grant_wr = (state_q == IDLE) & wr_elig & (~rd_elig | prio_wr_q);
    assign grant_rd = (state_q == IDLE) & rd_elig & (~wr_elig | ~prio_wr_q);

    assign idx_in_range = 32'(idx_q) < 32'(NUM_REGS);
    assign wr_ok        = idx_in_range & (&wstrb_q);

    always_comb begin
        idx_onehot = '0;
        slice_sel  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(idx_q) == 32'(i)) begin
                idx_onehot[i] = 1'b1;
                slice_sel     = mem_r_data_local[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_wr_d = prio_wr_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d   = WR_EXEC;
                    prio_wr_d = 1'b0;
                    idx_d     = s_awaddr[ADDR_WIDTH-1:2];
                    wdata_d   = s_wdata;
                    wstrb_d   = s_wstrb;
                end else if (grant_rd) begin
                    state_d   = RD_EXEC;
                    prio_wr_d = 1'b1;
                    idx_d     = s_araddr[ADDR_WIDTH-1:2];
                end
            end
            WR_EXEC: state_d = WR_RESP;
            WR_RESP: if (s_bready) state_d = IDLE;
            RD_EXEC: state_d = RD_CAPT;
            // Capture one cycle after the request so the slice has settled its read data.
            RD_CAPT: begin
                rdata_d = idx_in_range ? slice_sel : '0;
                state_d = RD_RESP;
            end
            RD_RESP: if (s_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_wr_q <= 1'b1;
            idx_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            prio_wr_q <= prio_wr_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
        end
    end

    // Outputs are forced low while rst is high so an aborted transaction never leaks a pulse.
    always_comb begin
        s_awready  = grant_wr & ~rst;
        s_wready   = grant_wr & ~rst;
        s_arready  = grant_rd & ~rst;
        s_bvalid   = ~rst & (state_q == WR_RESP);
        s_bresp    = s_bvalid ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : 2'b00;
        s_rvalid   = ~rst & (state_q == RD_RESP);
        s_rresp    = s_rvalid ? (idx_in_range ? RESP_OKAY : RESP_SLVERR) : 2'b00;
        s_rdata    = rst ? '0 : rdata_q;
        mem_w_req  = '0;
        mem_w_data = '0;
        if (~rst && (state_q == WR_EXEC) && wr_ok) begin
            mem_w_req  = idx_onehot;
            mem_w_data = wdata_q;
        end
        mem_r_req  = (~rst && (state_q == RD_EXEC)) ? idx_onehot : '0;
    end
endmodule

// File: tb/tb_vertexinput_reg_ctrl.sv
// Bench for vertexinput_reg_ctrl: randomized transactions against a transaction-level reference model.
module tb_vertexinput_reg_ctrl;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              s_awvalid, s_awready, s_wvalid, s_wready;
    logic [AW-1:0]     s_awaddr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic              s_bvalid, s_bready;
    logic [1:0]        s_bresp;
    logic              s_arvalid, s_arready;
    logic [AW-1:0]     s_araddr;
    logic              s_rvalid, s_rready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic [NR-1:0]     mem_w_req, mem_r_req;
    logic [DW-1:0]     mem_w_data;
    logic [NR*DW-1:0]  mem_r_data_local;
    logic [DW-1:0]     slice_val [NR];

    int passed = 0;
    int total  = 0;
    bit model_prio_wr = 1'b1;

    vertexinput_reg_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .mem_w_req(mem_w_req), .mem_w_data(mem_w_data), .mem_r_req(mem_r_req),
        .mem_r_data_local(mem_r_data_local)
    );

    always_comb begin
        mem_r_data_local = '0;
        for (int i = 0; i < NR; i++) mem_r_data_local[i*DW +: DW] = slice_val[i];
    end

    // Background invariants, tallied every cycle and compared at the end of the run.
    int cyc = 0, last_rpulse = -10;
    int overlap_err = 0, wdata_err = 0, rgap_err = 0, onehot_err = 0;
    always @(negedge clk) begin
        cyc++;
        if (mem_w_req != 0 && mem_r_req != 0) overlap_err++;
        if (mem_w_req == 0 && mem_w_data != 0) wdata_err++;
        if ($countones(mem_w_req) > 1 || $countones(mem_r_req) > 1) onehot_err++;
        if (mem_r_req != 0) begin
            if (cyc - last_rpulse < 3) rgap_err++;
            last_rpulse = cyc;
        end
    end

    function automatic bit in_range(input logic [AW-1:0] a);
        return int'(a >> 2) < NR;
    endfunction

    function automatic logic [NR-1:0] exp_onehot(input logic [AW-1:0] a);
        logic [NR-1:0] v;
        v = '0;
        if (in_range(a)) v[a >> 2] = 1'b1;
        return v;
    endfunction

    function automatic logic [88:0] all_outs();
        return {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp,
                s_rdata, mem_w_req, mem_w_data, mem_r_req};
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            output int lat, output int npulse, output logic [NR-1:0] req,
                            output logic [DW-1:0] wd, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        s_awvalid = 1; s_wvalid = 1; s_awaddr = a; s_wdata = d; s_wstrb = s; s_bready = 1;
        n = 0;
        @(negedge clk);
        while (!(s_awready && s_wready) && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0;
        lat = 0; npulse = 0; req = '0; wd = '0; resp = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_w_req != 0) begin npulse++; req = mem_w_req; wd = mem_w_data; end
            if (s_bvalid) begin lat = k; resp = s_bresp; break; end
        end
        @(posedge clk); #1;
        model_prio_wr = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int lat, output int npulse,
                           output logic [NR-1:0] req, output logic [DW-1:0] rd, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        s_arvalid = 1; s_araddr = a; s_rready = 1;
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_arvalid = 0;
        lat = 0; npulse = 0; req = '0; rd = '0; resp = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_r_req != 0) begin npulse++; req = mem_r_req; end
            if (s_rvalid) begin lat = k; rd = s_rdata; resp = s_rresp; break; end
        end
        @(posedge clk); #1;
        model_prio_wr = 1'b1;
    endtask

    task automatic test_reset();
        logic [88:0] o;
        rst = 1;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 0; s_rready = 0;
        s_awaddr = 8'h04; s_araddr = 8'h04; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = all_outs();
        total++; if (o !== '0) $display("FAIL reset_hold: outputs=%h expected 0", o); else passed++;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; rst = 0;
        @(negedge clk);
        o = all_outs();
        total++; if (o !== '0) $display("FAIL reset_idle: outputs=%h expected 0", o); else passed++;
        model_prio_wr = 1'b1;
    endtask

    task automatic test_write();
        int lat, np; logic [NR-1:0] req; logic [DW-1:0] wd; logic [1:0] rs;
        logic [AW-1:0] a; logic [DW-1:0] d; logic [3:0] s; bit perf;
        do_write(8'h08, 32'hDEAD_BEEF, 4'hF, lat, np, req, wd, rs);
        total++; if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else passed++;
        total++; if (np !== 1) $display("FAIL wr_pulses: got %0d expected 1", np); else passed++;
        total++; if (req !== 8'b0000_0100) $display("FAIL wr_req: got %b expected 00000100", req); else passed++;
        total++; if (wd !== 32'hDEAD_BEEF) $display("FAIL wr_data: got %h expected deadbeef", wd); else passed++;
        total++; if (rs !== 2'b00) $display("FAIL wr_bresp: got %b expected 00", rs); else passed++;
        for (int t = 0; t < 12; t++) begin
            a = 8'($urandom_range(0, 63));
            d = $urandom;
            s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            perf = in_range(a) && (s == 4'hF);
            do_write(a, d, s, lat, np, req, wd, rs);
            total++;
            if (lat !== 2 || np !== (perf ? 1 : 0) || req !== (perf ? exp_onehot(a) : '0)
                || wd !== (perf ? d : '0) || rs !== (perf ? 2'b00 : 2'b10))
                $display("FAIL wr_rand[%0d]: addr=%h strb=%h got lat=%0d n=%0d req=%b data=%h resp=%b expected lat=2 n=%0d req=%b data=%h resp=%b",
                         t, a, s, lat, np, req, wd, rs, perf ? 1 : 0, perf ? exp_onehot(a) : '0,
                         perf ? d : '0, perf ? 2'b00 : 2'b10);
            else passed++;
        end
    endtask

    task automatic test_read();
        int lat, np; logic [NR-1:0] req; logic [DW-1:0] rd; logic [1:0] rs; logic [AW-1:0] a;
        logic [DW-1:0] exp_d;
        slice_val[3] = 32'h0000_0005;
        do_read(8'h0C, lat, np, req, rd, rs);
        total++; if (lat !== 3) $display("FAIL rd_latency: got %0d expected 3", lat); else passed++;
        total++; if (np !== 1) $display("FAIL rd_pulses: got %0d expected 1", np); else passed++;
        total++; if (req !== 8'b0000_1000) $display("FAIL rd_req: got %b expected 00001000", req); else passed++;
        total++; if (rd !== 32'h5) $display("FAIL rd_data: got %h expected 00000005", rd); else passed++;
        total++; if (rs !== 2'b00) $display("FAIL rd_rresp: got %b expected 00", rs); else passed++;
        for (int t = 0; t < 12; t++) begin
            a = 8'($urandom_range(0, 63));
            for (int i = 0; i < NR; i++) slice_val[i] = $urandom;
            exp_d = in_range(a) ? slice_val[a >> 2] : '0;
            do_read(a, lat, np, req, rd, rs);
            total++;
            if (lat !== 3 || np !== (in_range(a) ? 1 : 0) || req !== exp_onehot(a) || rd !== exp_d
                || rs !== (in_range(a) ? 2'b00 : 2'b10))
                $display("FAIL rd_rand[%0d]: addr=%h got lat=%0d n=%0d req=%b data=%h resp=%b expected lat=3 req=%b data=%h",
                         t, a, lat, np, req, rd, rs, exp_onehot(a), exp_d);
            else passed++;
        end
    endtask

    task automatic test_out_of_range();
        int lat, np; logic [NR-1:0] req; logic [DW-1:0] dat; logic [1:0] rs;
        slice_val[0] = 32'hFFFF_FFFF;
        do_read(8'h20, lat, np, req, dat, rs);
        total++; if (np !== 0 || dat !== '0 || rs !== 2'b10 || lat !== 3)
            $display("FAIL oor_read: got n=%0d data=%h resp=%b lat=%0d expected n=0 data=0 resp=10 lat=3", np, dat, rs, lat);
        else passed++;
        do_write(8'h20, 32'hCAFE_F00D, 4'hF, lat, np, req, dat, rs);
        total++; if (np !== 0 || rs !== 2'b10 || lat !== 2)
            $display("FAIL oor_write: got n=%0d resp=%b lat=%0d expected n=0 resp=10 lat=2", np, rs, lat);
        else passed++;
        do_write(8'h00, 32'h1111_2222, 4'h3, lat, np, req, dat, rs);
        total++; if (np !== 0 || rs !== 2'b10 || lat !== 2)
            $display("FAIL partial_strobe: got n=%0d resp=%b lat=%0d expected n=0 resp=10 lat=2", np, rs, lat);
        else passed++;
    endtask

    task automatic conflict_round(input int tag);
        int n; bit got_w, got_r, exp_w;
        exp_w = model_prio_wr;
        @(posedge clk); #1;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
        s_awaddr = 8'($urandom_range(0, 31)); s_araddr = 8'($urandom_range(0, 31));
        s_wdata = $urandom; s_wstrb = 4'hF;
        n = 0;
        @(negedge clk);
        while (!(s_awready || s_arready) && n < 50) begin @(negedge clk); n++; end
        got_w = s_awready; got_r = s_arready;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        total++;
        if (got_w !== exp_w || got_r !== !exp_w)
            $display("FAIL arb_round[%0d]: got w=%0b r=%0b expected w=%0b r=%0b", tag, got_w, got_r, exp_w, !exp_w);
        else passed++;
        n = 0;
        @(negedge clk);
        while (!(s_bvalid || s_rvalid) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        model_prio_wr = !exp_w;
    endtask

    task automatic test_arbitration();
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        model_prio_wr = 1'b1;
        for (int r = 0; r < 4; r++) conflict_round(r);
    endtask

    task automatic test_back_to_back();
        int lat, np; logic [NR-1:0] req; logic [DW-1:0] dat; logic [1:0] rs;
        for (int r = 0; r < 8; r++) begin
            case ($urandom_range(0, 2))
                1: do_read(8'($urandom_range(0, 31)), lat, np, req, dat, rs);
                2: do_write(8'($urandom_range(0, 31)), $urandom, 4'hF, lat, np, req, dat, rs);
                default: ;
            endcase
            conflict_round(10 + r);
        end
    endtask

    task automatic test_backpressure();
        int n, idx; bit held_ok, grant_seen; logic [DW-1:0] exp_d;
        idx = $urandom_range(0, NR - 1);
        slice_val[idx] = $urandom;
        exp_d = slice_val[idx];
        @(posedge clk); #1;
        s_arvalid = 1; s_araddr = 8'(idx << 2); s_rready = 0;
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_arvalid = 0;
        n = 0;
        @(negedge clk);
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        total++; if (s_rvalid !== 1'b1 || s_rdata !== exp_d)
            $display("FAIL bp_first: got rvalid=%b data=%h expected rvalid=1 data=%h", s_rvalid, s_rdata, exp_d);
        else passed++;
        held_ok = 1; grant_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_awaddr = 8'h00; s_araddr = 8'h00;
            s_wstrb = 4'hF; slice_val[idx] = ~exp_d;
            @(negedge clk);
            if (s_rvalid !== 1'b1 || s_rdata !== exp_d) held_ok = 0;
            if (s_awready || s_wready || s_arready) grant_seen = 1;
        end
        total++; if (held_ok !== 1'b1) $display("FAIL bp_hold: got stable=%0b expected 1", held_ok); else passed++;
        total++; if (grant_seen !== 1'b0) $display("FAIL bp_no_grant: got grant=%0b expected 0", grant_seen); else passed++;
        @(posedge clk); #1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_rready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (s_rvalid !== 1'b0) $display("FAIL bp_release: got rvalid=%b expected 0", s_rvalid); else passed++;
        model_prio_wr = 1'b1;
    endtask

    task automatic test_reset_mid_read();
        int n, lat, np; bit rv_seen, rq_seen; logic [88:0] o;
        logic [NR-1:0] req; logic [DW-1:0] dat; logic [1:0] rs; logic [DW-1:0] exp_d;
        @(posedge clk); #1;
        s_arvalid = 1; s_araddr = 8'h04; s_rready = 1;
        n = 0;
        @(negedge clk);
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        s_arvalid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        o = all_outs();
        total++; if (o !== '0) $display("FAIL rst_capt_outs: outputs=%h expected 0", o); else passed++;
        @(posedge clk); #1;
        rst = 0;
        model_prio_wr = 1'b1;
        rv_seen = 0; rq_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (s_rvalid) rv_seen = 1;
            if (mem_r_req != 0) rq_seen = 1;
        end
        total++; if (rv_seen !== 1'b0 || rq_seen !== 1'b0)
            $display("FAIL rst_abort: got rvalid_seen=%0b rreq_seen=%0b expected 0 0", rv_seen, rq_seen);
        else passed++;
        slice_val[0] = $urandom;
        exp_d = slice_val[0];
        do_read(8'h00, lat, np, req, dat, rs);
        total++; if (lat !== 3 || np !== 1 || req !== 8'b1 || dat !== exp_d || rs !== 2'b00)
            $display("FAIL rst_resume: got lat=%0d n=%0d req=%b data=%h resp=%b expected lat=3 n=1 req=00000001 data=%h resp=00",
                     lat, np, req, dat, rs, exp_d);
        else passed++;
    endtask

    task automatic test_invariants();
        total++; if (overlap_err !== 0) $display("FAIL req_overlap: got %0d cycles expected 0", overlap_err); else passed++;
        total++; if (wdata_err !== 0) $display("FAIL wdata_idle: got %0d cycles expected 0", wdata_err); else passed++;
        total++; if (rgap_err !== 0) $display("FAIL rreq_spacing: got %0d violations expected 0", rgap_err); else passed++;
        total++; if (onehot_err !== 0) $display("FAIL req_onehot: got %0d cycles expected 0", onehot_err); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        for (int i = 0; i < NR; i++) slice_val[i] = $urandom;
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_arbitration();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_read();
        test_invariants();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
